// File: rtl/mc_controller_if.sv
// Control bus between the multicycle controller and its datapath: IR opcode
// and status flags in, mux selects and write strobes out.
interface mc_controller_if #(
    parameter int unsigned OPW = 4
);
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           mem_ready;

    logic           mem_req;
    logic           iord;
    logic           irwrite;
    logic           pcwrite;
    logic           memwrite;
    logic           regwrite;
    logic           regdst;
    logic           memtoreg;
    logic           alusrca;
    logic [1:0]     alusrcb;
    logic [1:0]     pcsrc;
    logic [1:0]     aluop;
    logic           halted;
    logic [3:0]     state;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, iord, irwrite, pcwrite, memwrite, regwrite,
               regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop, halted, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, iord, irwrite, pcwrite, memwrite, regwrite,
               regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop, halted, state
    );
endinterface

// File: rtl/mc_controller.sv
// Moore FSM controller for the 16-bit multicycle MIPS-style core with a
// variable-latency memory handshake. Optional counters: MC_CONTROLLER_PERF_EN.
module mc_controller #(
    parameter int unsigned OPW  = 4,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
`ifdef MC_CONTROLLER_PERF_EN
    ,
    output logic [CNTW-1:0] cycle_count,
    output logic [CNTW-1:0] instr_count
`endif
);

    if (OPW < 4 || CNTW < 1) begin : g_param_check
        $error("mc_controller: OPW must be >= 4 and CNTW >= 1");
    end

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(0);
    localparam logic [OPW-1:0] OP_LW    = OPW'(1);
    localparam logic [OPW-1:0] OP_SW    = OPW'(2);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(3);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(4);
    localparam logic [OPW-1:0] OP_J     = OPW'(5);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEXEC = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        HALT   = 4'd12
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic       mem_req;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       halted;

    // State register; reset is synchronous and always lands in FETCH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        halted   = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = bus.mem_ready;
                pcwrite = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // Branch target is precomputed here while the opcode is decoded.
                alusrcb = 2'b11;
                case (bus.opcode)
                    OP_RTYPE:     state_d = RTEXEC;
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = HALT;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                if (bus.mem_ready) begin
                    state_d = FETCH;
                end
            end
            RTEXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                pcwrite = bus.zero;
                state_d = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = FETCH;
            end
            HALT: begin
                halted  = 1'b1;
                state_d = HALT;
            end
            default: state_d = FETCH;
        endcase

        // No side effects may escape while reset is held.
        if (!reset) begin
            mem_req  = 1'b0;
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
        end
    end

    assign bus.mem_req  = mem_req;
    assign bus.iord     = iord;
    assign bus.irwrite  = irwrite;
    assign bus.pcwrite  = pcwrite;
    assign bus.memwrite = memwrite;
    assign bus.regwrite = regwrite;
    assign bus.regdst   = regdst;
    assign bus.memtoreg = memtoreg;
    assign bus.alusrca  = alusrca;
    assign bus.alusrcb  = alusrcb;
    assign bus.pcsrc    = pcsrc;
    assign bus.aluop    = aluop;
    assign bus.halted   = halted;
    assign bus.state    = state_q;

`ifdef MC_CONTROLLER_PERF_EN
    logic instr_done;

    // An instruction retires when a terminal state hands back to FETCH.
    assign instr_done = (state_d == FETCH) &&
                        (state_q inside {MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP});

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (state_q != HALT) begin
                cycle_count <= cycle_count + CNTW'(1);
            end
            if (instr_done) begin
                instr_count <= instr_count + CNTW'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction expected cycle
// sequences built from the instruction semantics, with random waits/opcodes.
module tb_mc_controller;
    localparam int unsigned OPW  = 4;
    localparam int unsigned CNTW = 4;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       halted;
    } ctl_t;

    typedef struct {
        logic [3:0]     st;
        logic [OPW-1:0] op;
        logic           mr;
        logic           z;
        ctl_t           c;
        bit             last;
    } step_t;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    int   cyc_m;
    int   ins_m;
    step_t q[$];

    mc_controller_if #(.OPW(OPW)) bus ();

`ifdef MC_CONTROLLER_PERF_EN
    logic [CNTW-1:0] cycle_count;
    logic [CNTW-1:0] instr_count;
`endif

    mc_controller #(.OPW(OPW), .CNTW(CNTW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef MC_CONTROLLER_PERF_EN
        ,
        .cycle_count(cycle_count),
        .instr_count(instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [OPW-1:0] ro();
        return OPW'($urandom);
    endfunction

    function automatic ctl_t observed();
        return {bus.mem_req, bus.iord, bus.irwrite, bus.pcwrite, bus.memwrite,
                bus.regwrite, bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb,
                bus.pcsrc, bus.aluop, bus.halted};
    endfunction

    function automatic void push(input logic [3:0] st, input logic [OPW-1:0] op,
                                 input logic mr, input logic z, input ctl_t c, input bit last);
        step_t s;
        s.st = st; s.op = op; s.mr = mr; s.z = z; s.c = c; s.last = last;
        q.push_back(s);
    endfunction

    // Expected cycles of one instruction: fw fetch waits, mw memory waits.
    function automatic void add_instr(input logic [OPW-1:0] op, input int fw,
                                      input int mw, input logic z);
        ctl_t c;
        c = '0; c.mem_req = 1'b1; c.alusrcb = 2'b01;
        for (int i = 0; i < fw; i++) push(4'd0, ro(), 1'b0, rb(), c, 1'b0);
        c.irwrite = 1'b1; c.pcwrite = 1'b1;
        push(4'd0, ro(), 1'b1, rb(), c, 1'b0);
        c = '0; c.alusrcb = 2'b11;
        push(4'd1, op, rb(), rb(), c, 1'b0);
        case (op)
            OPW'(0): begin
                c = '0; c.alusrca = 1'b1; c.aluop = 2'b10;
                push(4'd6, ro(), rb(), rb(), c, 1'b0);
                c = '0; c.regwrite = 1'b1; c.regdst = 1'b1;
                push(4'd7, ro(), rb(), rb(), c, 1'b1);
            end
            OPW'(1), OPW'(2): begin
                c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10;
                push(4'd2, op, rb(), rb(), c, 1'b0);
                c = '0; c.mem_req = 1'b1; c.iord = 1'b1;
                c.memwrite = (op == OPW'(2));
                for (int i = 0; i < mw; i++)
                    push((op == OPW'(2)) ? 4'd5 : 4'd3, ro(), 1'b0, rb(), c, 1'b0);
                push((op == OPW'(2)) ? 4'd5 : 4'd3, ro(), 1'b1, rb(), c, op == OPW'(2));
                if (op == OPW'(1)) begin
                    c = '0; c.regwrite = 1'b1; c.memtoreg = 1'b1;
                    push(4'd4, ro(), rb(), rb(), c, 1'b1);
                end
            end
            OPW'(3): begin
                c = '0; c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pcwrite = z;
                push(4'd8, ro(), rb(), z, c, 1'b1);
            end
            OPW'(4): begin
                c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10;
                push(4'd9, ro(), rb(), rb(), c, 1'b0);
                c = '0; c.regwrite = 1'b1;
                push(4'd10, ro(), rb(), rb(), c, 1'b1);
            end
            OPW'(5): begin
                c = '0; c.pcsrc = 2'b10; c.pcwrite = 1'b1;
                push(4'd11, ro(), rb(), rb(), c, 1'b1);
            end
            default: begin
                c = '0; c.halted = 1'b1;
                push(4'd12, ro(), rb(), rb(), c, 1'b0);
            end
        endcase
    endfunction

    // Each step is entered at a falling edge: drive, settle, check, advance.
    task automatic run_queue();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            bus.opcode = s.op; bus.mem_ready = s.mr; bus.zero = s.z;
            #1;
            n_assert++;
            assert (bus.state === s.st) else begin
                n_fail++;
                $error("FAIL state: observed %0d expected %0d", bus.state, s.st);
            end
            n_assert++;
            assert (observed() === s.c) else begin
                n_fail++;
                $error("FAIL ctl st=%0d: observed %h expected %h", s.st, observed(), s.c);
            end
`ifdef MC_CONTROLLER_PERF_EN
            n_assert++;
            assert (cycle_count === CNTW'(cyc_m)) else begin
                n_fail++;
                $error("FAIL cycle_count: observed %0d expected %0d", cycle_count, CNTW'(cyc_m));
            end
            n_assert++;
            assert (instr_count === CNTW'(ins_m)) else begin
                n_fail++;
                $error("FAIL instr_count: observed %0d expected %0d", instr_count, CNTW'(ins_m));
            end
`endif
            if (s.st != 4'd12) cyc_m++;
            if (s.last) ins_m++;
            @(negedge clk);
        end
    endtask

    // Hold reset n cycles (state already FETCH), then release at a falling edge.
    task automatic do_reset(input int n);
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        bus.zero = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            n_assert++;
            assert ({bus.mem_req, bus.irwrite, bus.pcwrite, bus.memwrite, bus.regwrite} === 5'b0)
            else begin
                n_fail++;
                $error("FAIL reset_strobes: observed %b expected 00000",
                       {bus.mem_req, bus.irwrite, bus.pcwrite, bus.memwrite, bus.regwrite});
            end
            @(negedge clk);
        end
        n_assert++;
        assert (bus.state === 4'd0) else begin
            n_fail++;
            $error("FAIL reset_state: observed %0d expected 0", bus.state);
        end
        cyc_m = 0;
        ins_m = 0;
        reset = 1'b1;
    endtask

    initial begin
        step_t tmp;
        ctl_t  c;
        n_assert = 0; n_fail = 0; cyc_m = 0; ins_m = 0;
        reset = 1'b0;
        bus.opcode = '0; bus.mem_ready = 1'b1; bus.zero = 1'b0;
        @(negedge clk);
        do_reset(2);

        // R-type then LW with three MEMRD waits, BEQ taken and not taken
        add_instr(OPW'(0), 0, 0, 1'b0);
        add_instr(OPW'(1), 0, 3, 1'b0);
        add_instr(OPW'(3), 0, 0, 1'b1);
        add_instr(OPW'(3), 0, 0, 1'b0);
        add_instr(OPW'(4), 1, 0, 1'b0);
        add_instr(OPW'(5), 2, 0, 1'b0);
        add_instr(OPW'(2), 0, 2, 1'b0);
        run_queue();

        // Random legal instruction mix with random waits
        for (int i = 0; i < 60; i++)
            add_instr(OPW'($urandom_range(0, 5)), $urandom_range(0, 3),
                      $urandom_range(0, 3), rb());
        run_queue();

        // SW with reset pulled low while MEMWR is waiting
        add_instr(OPW'(2), 0, 3, 1'b0);
        void'(q.pop_back());
        void'(q.pop_back());
        run_queue();
        reset = 1'b0; bus.mem_ready = 1'b0;
        #1;
        n_assert++;
        assert (bus.state === 4'd5) else begin
            n_fail++; $error("FAIL sw_wait_state: observed %0d expected 5", bus.state);
        end
        n_assert++;
        assert ({bus.memwrite, bus.mem_req} === 2'b00) else begin
            n_fail++; $error("FAIL sw_reset_strobes: observed %b expected 00", {bus.memwrite, bus.mem_req});
        end
        @(posedge clk);
        #1;
        n_assert++;
        assert (bus.state === 4'd0) else begin
            n_fail++; $error("FAIL sw_reset_next: observed %0d expected 0", bus.state);
        end
        @(negedge clk);
        do_reset(1);

        // Illegal opcode halts and stays halted for 20 cycles
        add_instr(OPW'(9), 0, 0, 1'b0);
        c = '0; c.halted = 1'b1;
        for (int i = 0; i < 20; i++) push(4'd12, ro(), rb(), rb(), c, 1'b0);
        run_queue();
        do_reset(2);
        add_instr(OPW'($urandom_range(6, 15)), 1, 0, 1'b0);
        push(4'd12, ro(), rb(), rb(), c, 1'b0);
        run_queue();
        do_reset(1);

        // Five zero-wait R-types: 20 cycles wraps a 4-bit counter to 4
        for (int i = 0; i < 5; i++) add_instr(OPW'(0), 0, 0, 1'b0);
        run_queue();
`ifdef MC_CONTROLLER_PERF_EN
        n_assert++;
        assert (instr_count === 4'd5) else begin
            n_fail++; $error("FAIL perf_instr: observed %0d expected 5", instr_count);
        end
        n_assert++;
        assert (cycle_count === 4'd4) else begin
            n_fail++; $error("FAIL perf_cycle: observed %0d expected 4", cycle_count);
        end
`endif
        tmp.st = bus.state;
        n_assert++;
        assert (tmp.st === 4'd0) else begin
            n_fail++; $error("FAIL final_state: observed %0d expected 0", tmp.st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle successor to the single-cycle CPU controller for the 16-bit MIPS-style core.
- Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles. This lets datapath ALU and memory be shared.
- Adds a memory ready/request handshake for variable-latency memory, an illegal-opcode halt, and parametrised opcode width.
- Sits between instruction register opcode field and multicycle datapath muxes/enables; aludec consumes aluop.

Parameters:
- OPW, 4, opcode field width (>=4); opcodes below are zero-extended to OPW.
- CNTW, 16, width of performance counters (optional feature only).

Ports:
- clk  input  1  core clock, all state updates on rising edge
- reset  input  1  synchronous, active-low; sampled on rising clk edge
- opcode  input  OPW  opcode field from instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes current access this cycle
- mem_req  output  1  memory access request
- iord  output  1  0 = address from PC, 1 = from ALUOut
- irwrite  output  1  instruction register load
- pcwrite  output  1  PC load (unconditional or branch-qualified)
- memwrite  output  1  memory write strobe
- regwrite  output  1  register file write
- regdst  output  1  0 = rt dest, 1 = rd dest
- memtoreg  output  1  0 = ALUOut, 1 = memory data
- alusrca  output  1  0 = PC, 1 = reg A
- alusrcb  output  2  00 = reg B, 01 = constant 2, 10 = signext imm, 11 = imm<<1
- pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- aluop  output  2  00 = add, 01 = sub, 10 = funct-decoded
- halted  output  1  FSM in HALT
- state  output  4  current state encoding (debug)

Behaviour:
- Opcode map: 0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J. Every other value is illegal.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, HALT 12. Codes 13-15 are unreachable and return to FETCH.
- reset low at clk edge: state <= FETCH. While reset is low, all strobes (mem_req, irwrite, pcwrite, memwrite, regwrite) are forced to 0.
- Unlisted outputs are 0 in each state.
- FETCH:
  - Outputs: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite=pcwrite=mem_ready.
  - Transitions: stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11, aluop=00 (branch target precompute).
  - Transitions: RTYPE -> RTEXEC; LW/SW -> MEMADR; BEQ -> BRANCH; ADDI -> ADDIEX; J -> JUMP; illegal -> HALT.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Go to MEMRD for LW, MEMWR for SW.
- MEMRD: mem_req=1, iord=1. Wait for mem_ready, then MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1. Go to FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1. Hold until mem_ready, then FETCH.
- RTEXEC: alusrca=1, alusrcb=00, aluop=10. Go to ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0. Go to FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcwrite=zero. Go to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Go to ADDIWB.
- ADDIWB: regwrite=1, regdst=0. Go to FETCH.
- JUMP: pcsrc=10, pcwrite=1. Go to FETCH.
- HALT: halted=1, all strobes 0. Remains in HALT until reset.
- Cycle counts with zero-wait memory: R/ADDI 4, LW 5, SW 4, BEQ 3, J 3.
- Each memory wait cycle adds 1 cycle. Strobes are held stable for the whole wait.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- opcode is sampled only in DECODE and MEMADR; the IR is stable there.
- Reset mid-access (e.g. MEMWR waiting): next state is FETCH. memwrite drops in the same cycle reset is low.

Optional Feature:
- Macro MC_CONTROLLER_PERF_EN.
- When defined: adds output ports cycle_count (CNTW) and instr_count (CNTW).
  - cycle_count increments every clk while reset is high and the FSM is not halted.
  - instr_count increments on each transition into FETCH from a terminal state: MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP.
  - Both counters wrap modulo 2^CNTW and clear to 0 on reset.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset low 2 cycles, then high, mem_ready=1, opcode=0 -> states 0,1,6,7,0. ALUWB has regwrite=1, regdst=1. No strobes during reset.
- opcode=1 (LW), mem_ready low 3 cycles in MEMRD -> MEMRD is held 4 cycles with mem_req=1, iord=1, then MEMWB with memtoreg=1, regwrite=1. LW total 8 cycles.
- opcode=3 (BEQ), zero=1, then a repeat with zero=0 -> BRANCH has pcsrc=01 and pcwrite=1 for the first pass, pcwrite=0 for the second. Each pass is 3 cycles.
- opcode=2 (SW), reset pulled low during MEMWR wait -> memwrite=0 in the reset cycle; state=0 after the edge.
- opcode=9 (illegal) -> DECODE then HALT (state=12, halted=1). Stays in HALT across 20 cycles with all strobes 0 until reset.
- PERF_EN, CNTW=4: run 5 R-type instructions with zero wait -> instr_count=5, cycle_count=20 wraps to 4.
